// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule: walks from the round-10 key back to the
// cipher key, one round key per accepted advance.
module aes_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_s = SBOX[i_a];
endmodule

module aes_inv_key_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key_in,
    input  logic         adv,
    output logic [127:0] rkey,
    output logic [3:0]   rnd,
    output logic         rkey_vld,
    output logic         done
);
    logic [127:0] r_rkey;
    logic [3:0]   r_rnd;
    logic         r_vld;
    logic         r_done;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_p0, w_p1, w_p2, w_p3;
    logic [31:0]  w_rot, w_sub;
    logic [7:0]   w_rcon;
    logic [127:0] w_step;

    assign {w_w0, w_w1, w_w2, w_w3} = r_rkey;

    assign w_p3 = w_w3 ^ w_w2;
    assign w_p2 = w_w2 ^ w_w1;
    assign w_p1 = w_w1 ^ w_w0;
    assign w_rot = {w_p3[23:0], w_p3[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (
                .i_a (w_rot[8*g +: 8]),
                .o_s (w_sub[8*g +: 8])
            );
        end
    endgenerate

    // Round constants run backwards: leaving round r uses rcon(r).
    always_comb begin
        w_rcon = 8'h00;
        case (r_rnd)
            4'd10:   w_rcon = 8'h36;
            4'd9:    w_rcon = 8'h1b;
            4'd8:    w_rcon = 8'h80;
            4'd7:    w_rcon = 8'h40;
            4'd6:    w_rcon = 8'h20;
            4'd5:    w_rcon = 8'h10;
            4'd4:    w_rcon = 8'h08;
            4'd3:    w_rcon = 8'h04;
            4'd2:    w_rcon = 8'h02;
            4'd1:    w_rcon = 8'h01;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_p0   = w_w0 ^ w_sub ^ {w_rcon, 24'h0};
    assign w_step = {w_p0, w_p1, w_p2, w_p3};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rkey <= '0;
            r_rnd  <= '0;
            r_vld  <= 1'b0;
            r_done <= 1'b0;
        end else if (kld) begin
            r_rkey <= key_in;
            r_rnd  <= 4'd10;
            r_vld  <= 1'b1;
            r_done <= 1'b0;
        end else if (r_vld && adv) begin
            if (r_rnd != 4'd0) begin
                r_rkey <= w_step;
                r_rnd  <= r_rnd - 4'd1;
                r_done <= 1'b0;
            end else begin
                r_vld  <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign rkey     = r_rkey;
    assign rnd      = r_rnd;
    assign rkey_vld = r_vld;
    assign done     = r_done;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using the FIPS-197 A.1 schedule.
module tb_aes_inv_key_sched;
    logic         clk = 1'b0;
    logic         rst;
    logic         kld;
    logic [127:0] key_in;
    logic         adv;
    logic [127:0] rkey;
    logic [3:0]   rnd;
    logic         rkey_vld;
    logic         done;

    int n_chk  = 0;
    int n_fail = 0;

    logic [127:0] exp_k [0:10];

    always #5 clk = ~clk;

    aes_inv_key_sched dut (
        .clk      (clk),
        .rst      (rst),
        .kld      (kld),
        .key_in   (key_in),
        .adv      (adv),
        .rkey     (rkey),
        .rnd      (rnd),
        .rkey_vld (rkey_vld),
        .done     (done)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] k);
        kld    = 1'b1;
        key_in = k;
        tick();
        kld    = 1'b0;
    endtask

    initial begin
        int cur;
        int cyc;
        bit got_done;
        exp_k[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_k[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_k[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_k[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_k[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_k[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_k[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_k[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_k[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_k[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_k[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset beats a simultaneous load and advance.
        rst    = 1'b1;
        kld    = 1'b1;
        adv    = 1'b1;
        key_in = exp_k[10];
        tick();
        tick();
        check("rst_rkey", rkey, 128'h0);
        check("rst_rnd", 128'(rnd), 128'h0);
        check("rst_vld", 128'(rkey_vld), 128'h0);
        check("rst_done", 128'(done), 128'h0);
        rst = 1'b0;
        kld = 1'b0;
        adv = 1'b0;
        tick();

        // Gapless walk.
        load(exp_k[10]);
        check("ld_rkey", rkey, exp_k[10]);
        check("ld_rnd", 128'(rnd), 128'd10);
        check("ld_vld", 128'(rkey_vld), 128'h1);
        check("ld_done", 128'(done), 128'h0);
        adv = 1'b1;
        for (int r = 9; r >= 0; r--) begin
            tick();
            check($sformatf("walk_rkey%0d", r), rkey, exp_k[r]);
            check($sformatf("walk_rnd%0d", r), 128'(rnd), 128'(r));
            check("walk_vld", 128'(rkey_vld), 128'h1);
            check("walk_done", 128'(done), 128'h0);
        end
        tick();
        check("fin_done", 128'(done), 128'h1);
        check("fin_vld", 128'(rkey_vld), 128'h0);
        check("fin_rkey", rkey, exp_k[0]);
        check("fin_rnd", 128'(rnd), 128'h0);

        // Idle advances after completion.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_done", 128'(done), 128'h0);
            check("idle_vld", 128'(rkey_vld), 128'h0);
            check("idle_rkey", rkey, exp_k[0]);
            check("idle_rnd", 128'(rnd), 128'h0);
        end
        adv = 1'b0;

        // Random stalls must reproduce the same key sequence.
        load(exp_k[10]);
        cur = 10;
        got_done = 1'b0;
        cyc = 0;
        while (!got_done && cyc < 300) begin
            logic a;
            a   = 1'($urandom_range(0, 1));
            adv = a;
            tick();
            cyc++;
            if (a && cur == 0) begin
                got_done = 1'b1;
                check("stall_done", 128'(done), 128'h1);
                check("stall_vld", 128'(rkey_vld), 128'h0);
            end else begin
                if (a) cur--;
                check("stall_rkey", rkey, exp_k[cur]);
                check("stall_rnd", 128'(rnd), 128'(cur));
                check("stall_dlo", 128'(done), 128'h0);
            end
        end
        check("stall_bound", 128'(got_done), 128'h1);
        adv = 1'b0;
        tick();

        // Restart mid-walk: kld wins over a coincident adv.
        load(exp_k[10]);
        adv = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("rs_rnd4", 128'(rnd), 128'd4);
        check("rs_rkey4", rkey, exp_k[4]);
        kld    = 1'b1;
        key_in = exp_k[5];
        tick();
        kld = 1'b0;
        adv = 1'b0;
        check("rs_rnd", 128'(rnd), 128'd10);
        check("rs_rkey", rkey, exp_k[5]);
        check("rs_vld", 128'(rkey_vld), 128'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rs_nodone", 128'(done), 128'h0);
            check("rs_hold", 128'(rnd), 128'd10);
        end

        // Mid-walk reset.
        load(exp_k[10]);
        adv = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("mr_rnd6", 128'(rnd), 128'd6);
        adv = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_rkey", rkey, 128'h0);
        check("mr_rnd", 128'(rnd), 128'h0);
        check("mr_vld", 128'(rkey_vld), 128'h0);
        check("mr_done", 128'(done), 128'h0);
        adv = 1'b1;
        tick();
        check("mr_adv_vld", 128'(rkey_vld), 128'h0);
        check("mr_adv_done", 128'(done), 128'h0);
        adv = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
